// File: rtl/channel_llr_loader.sv
// Channel LLR loader: quantises a serial soft-sample stream and packs Z samples per lifted column
// into a ping-pong buffer pair. Optional LLR_PUNCTURE_EN emits the first two columns as zero LLRs.
module channel_llr_loader #(
    parameter int unsigned Z          = 56,
    parameter int unsigned IN_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned SHIFT      = 2,
    parameter int unsigned MAX_COLS   = 68
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [6:0]                   num_cols,
    input  logic signed [IN_WIDTH-1:0]   in_llr,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [Z*DATA_WIDTH-1:0]      channel_llr,
    output logic                         channel_llr_valid,
    input  logic                         channel_llr_ready,
    output logic [6:0]                   col_idx,
    output logic                         col_last,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned COL_W  = Z * DATA_WIDTH;
    localparam int unsigned ELEM_W = (Z > 1) ? $clog2(Z) : 1;
    localparam int unsigned QW     = IN_WIDTH + 1;
    localparam logic signed [QW-1:0] RND  = QW'((1 << SHIFT) >> 1);
    localparam logic signed [QW-1:0] QMAX = QW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [QW-1:0] QMIN = -QMAX;

    typedef enum logic [1:0] {IDLE, PUNCT, FILL, DRAIN} state_t;

    state_t                  state;
    logic [COL_W-1:0]        col_buf [2];
    logic [1:0]              full;
    logic                    wp;
    logic                    rp;
    logic [ELEM_W-1:0]       elem;
    logic [6:0]              prod;
    logic [6:0]              ncols;

    logic signed [QW-1:0]         t_sum;
    logic signed [QW-1:0]         t_shift;
    logic signed [DATA_WIDTH-1:0] q;
    logic                         take;
    logic                         accept;
    logic                         start_ok;
    logic                         drain_empty;
    logic [6:0]                   punct_cols;

    // Round-half-up, arithmetic shift, symmetric saturation (most-negative code never produced)
    always_comb begin
        t_sum   = $signed({in_llr[IN_WIDTH-1], in_llr}) + RND;
        t_shift = t_sum >>> SHIFT;
        if (t_shift > QMAX) begin
            q = DATA_WIDTH'(QMAX);
        end else if (t_shift < QMIN) begin
            q = DATA_WIDTH'(QMIN);
        end else begin
            q = DATA_WIDTH'(t_shift);
        end
    end

    assign in_ready          = (state == FILL) && !full[wp];
    assign channel_llr_valid = full[rp];
    assign channel_llr       = col_buf[rp];
    assign col_last          = (col_idx == (ncols - 7'd1));

    assign take        = full[rp] && channel_llr_ready;
    assign accept      = in_ready && in_valid;
    assign start_ok    = start && (num_cols != 7'd0) && (num_cols <= 7'(MAX_COLS));
    assign punct_cols  = (ncols < 7'd2) ? ncols : 7'd2;
    // Both buffers will be empty after this edge (no fills happen while draining)
    assign drain_empty = ((full & ~(take ? (2'b01 << rp) : 2'b00)) == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col_buf[0] <= '0;
            col_buf[1] <= '0;
            full       <= 2'b00;
            wp         <= 1'b0;
            rp         <= 1'b0;
            elem       <= '0;
            prod       <= 7'd0;
            ncols      <= 7'd0;
            col_idx    <= 7'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            // Hand-off side runs independently of the fill state
            if (take) begin
                full[rp] <= 1'b0;
                rp       <= ~rp;
                col_idx  <= col_idx + 7'd1;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        ncols   <= num_cols;
                        prod    <= 7'd0;
                        elem    <= '0;
                        col_idx <= 7'd0;
                        busy    <= 1'b1;
`ifdef LLR_PUNCTURE_EN
                        state   <= PUNCT;
`else
                        state   <= FILL;
`endif
                    end
                end
                PUNCT: begin
                    if (!full[wp]) begin
                        col_buf[wp] <= '0;
                        full[wp]    <= 1'b1;
                        wp          <= ~wp;
                        prod        <= prod + 7'd1;
                        if ((prod + 7'd1) == punct_cols) begin
                            state <= (ncols > punct_cols) ? FILL : DRAIN;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        col_buf[wp][elem*DATA_WIDTH +: DATA_WIDTH] <= q;
                        if (elem == ELEM_W'(Z - 1)) begin
                            full[wp] <= 1'b1;
                            wp       <= ~wp;
                            elem     <= '0;
                            prod     <= prod + 7'd1;
                            if ((prod + 7'd1) == ncols) begin
                                state <= DRAIN;
                            end
                        end else begin
                            elem <= elem + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_empty) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/channel_llr_loader.md
# channel_llr_loader

Upstream feeder for the variable node decoder. It accepts a serial stream of wide soft samples from the demapper, then rounds, shifts and saturates each one to the decoder message width. It packs Z consecutive samples into one lifted column and hands that column over as a Z-wide `channel_llr` vector under a valid/ready handshake. A ping-pong pair of column buffers lets input filling overlap with output hand-off.

## Interface
Parameters:
- `Z`, 56, lifting factor; elements per column.
- `IN_WIDTH`, 8, signed input sample width.
- `DATA_WIDTH`, 6, signed output LLR width; must match the VN decoder.
- `SHIFT`, 2, arithmetic right shift applied during quantisation (0..IN_WIDTH-2).
- `MAX_COLS`, 68, maximum columns per codeword (BG1).

Ports:
- `clk`  in  1  clock; one clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  pulse; begins a codeword and latches `num_cols`.
- `num_cols`  in  7  columns in this codeword, including punctured columns (1..MAX_COLS).
- `in_llr`  in  IN_WIDTH signed  input soft sample.
- `in_valid`  in  1  `in_llr` is valid.
- `in_ready`  out  1  loader accepts a sample this cycle.
- `channel_llr`  out  [Z-1:0] x DATA_WIDTH signed  packed column.
- `channel_llr_valid`  out  1  column available.
- `channel_llr_ready`  in  1  consumer takes the column.
- `col_idx`  out  7  index of the presented column (0-based).
- `col_last`  out  1  presented column is the final one of the codeword.
- `busy`  out  1  a codeword is in progress.
- `done`  out  1  one-cycle pulse after the last column is taken.

## Operation
- Quantisation is performed in IN_WIDTH+1 bits.
  - `t = in_llr + (SHIFT>0 ? 1<<(SHIFT-1) : 0)`, then `t >>>= SHIFT`.
  - The result saturates symmetrically to ±(2^(DATA_WIDTH-1)-1). The most-negative code is never emitted.
- Buffers: two column buffers, `buf[0]` and `buf[1]`, each with a `full` flag, plus a fill pointer `wp` and a read pointer `rp`. Both pointers reset to 0.
- States:
  - **IDLE**
    - On `start` with `num_cols` in 1..MAX_COLS, latch `num_cols`, clear the column counter, set `busy`, and go to PUNCT (macro defined) or FILL (macro undefined).
    - `start` with `num_cols` of 0 or greater than MAX_COLS is ignored.
  - **PUNCT**
    - When `buf[wp]` is not full, write an all-zero column into it in one cycle, set `full`, toggle `wp`, and increment the produced count.
    - Exit after min(2, `num_cols`) columns: go to FILL if columns remain, otherwise go to DRAIN.
  - **FILL**
    - `in_ready = !full[wp]`. Each accepted sample is written to element `elem` of `buf[wp]`, and `elem` increments.
    - When `elem` reaches Z-1 and that sample is accepted, set `full[wp]`, toggle `wp`, clear `elem`, and increment the produced count.
    - When the produced count equals `num_cols`, go to DRAIN.
  - **DRAIN**
    - `in_ready = 0`. Wait until both `full` flags are clear, then pulse `done`, clear `busy`, and return to IDLE.
- Output side, independent of state:
  - `channel_llr_valid = full[rp]`, and `channel_llr = buf[rp]`.
  - On `channel_llr_valid && channel_llr_ready`: clear `full[rp]`, toggle `rp`, and increment `col_idx`.
  - `col_last = (col_idx == num_cols-1)`.
  - `col_idx` clears on accepted `start`.
- `start` while `busy` is ignored.
- Output data is held stable while `valid` is high and `ready` is low.

## Timing
- Reset values:
  - `in_ready`, `channel_llr_valid`, `col_last`, `busy`, `done`: 0.
  - `col_idx`: 0.
  - `channel_llr`: all zeros.
  - State IDLE; all `full` flags clear.
- Latency:
  - The column goes valid in the cycle after its Z-th sample is accepted.
  - A punctured column goes valid in the cycle after it is written.
- Throughput: one sample per cycle. With `channel_llr_ready` held high there are no input bubbles; the next column fills while the previous one is presented.
- Both buffers full: `in_ready` is 0 until a hand-off occurs. The hand-off and a fill completion may land in the same cycle; both flag updates apply.
- `done` asserts in the cycle after the final hand-off.
- Reset mid-codeword: everything returns to reset values immediately, and partial columns are discarded.

## Configuration
- `LLR_PUNCTURE_EN` defined:
  - The first min(2, `num_cols`) columns of each codeword are emitted as zero LLRs and consume no input. This models the 5G NR 2Z systematic puncturing.
- `LLR_PUNCTURE_EN` undefined:
  - PUNCT is never entered, and every column is filled from `in_llr`.

## Test plan
Bench parameters: Z=4, IN_WIDTH=8, DATA_WIDTH=6, SHIFT=2.
1. Quantisation: inputs 37, 6, -6, 127, -128 → 9, 2, -1, 31 (saturated), -31 (saturated).
2. Macro undefined, `num_cols`=3, ready held high, 12 samples back-to-back:
   - 3 columns, `col_idx` 0/1/2, `col_last` on column 2.
   - `in_ready` never drops.
   - `done` one cycle after the last hand-off.
3. Back-pressure with `channel_llr_ready` held low:
   - After 8 samples, `in_ready` goes 0 and `channel_llr` stays stable.
   - Raising ready for 1 cycle frees exactly one buffer.
4. `LLR_PUNCTURE_EN` defined, `num_cols`=4:
   - Columns 0-1 are all zero with no input consumed.
   - Columns 2-3 are built from 8 samples.
5. `start` while busy, and `start` with `num_cols`=0: both ignored, with no state change.
6. `rst_n` low mid-column 1: all outputs go to reset values asynchronously; a fresh `start` then runs cleanly.
